// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frogger_pkg
// Description : Shared direction encodings, move-FSM states and the
//               first-press priority helper used by the input conditioner
//               and the frog-position logic.
// Revision    : 1.0 - initial release
// ============================================================================
package frogger_pkg;

  // Move direction as seen by the frog-position logic.
  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  // Move-issue state machine.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DELAY   = 3'd2,
    REPEAT  = 3'd3,
    RELEASE = 3'd4
  } move_state_e;

  localparam int unsigned c_num_buttons = 4;

  // Resolve simultaneous presses: right beats left beats up beats down.
  // Bit order of held is {d,u,l,r}.
  function automatic dir_e pick_dir(input logic [3:0] held);
    if (held[0]) begin
      return DIR_R;
    end else if (held[1]) begin
      return DIR_L;
    end else if (held[2]) begin
      return DIR_U;
    end else begin
      return DIR_D;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : move_input_conditioner_if
// Description : Raw push-button inputs plus the move valid/ready command
//               channel and debounced button levels.
//               master = the conditioner, slave = buttons + move consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_input_conditioner_if;

  logic       move_r;      // raw, active-low
  logic       move_l;      // raw, active-low
  logic       move_u;      // raw, active-low
  logic       move_d;      // raw, active-low
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] held;        // debounced, active-high, {d,u,l,r}

  modport master (
    input  move_r, move_l, move_u, move_d, move_ready,
    output move_valid, move_dir, held
  );

  modport slave (
    output move_r, move_l, move_u, move_d, move_ready,
    input  move_valid, move_dir, held
  );

endinterface
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One push-button channel: 2-flop synchronizer with inversion
//               to active-high, then a consecutive-sample debounce counter.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  wire logic VGA_CLK,
  input  wire logic reset,
  input  wire logic raw_n_i,
  output logic      level_o
);

  localparam int unsigned c_cnt_w = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q;
  logic               sync2_q;
  logic               level_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;
  logic               level_d;

  // Bring the asynchronous button into the clock domain; a pressed (low) button reads as 1.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~raw_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_cnt_last) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce counter and accepted level registers.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/move_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : move_input_conditioner
// Description : Debounces four direction buttons and turns presses into
//               valid/ready move commands with hold-to-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module move_input_conditioner
  import frogger_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  wire logic                 VGA_CLK,
  input  wire logic                 reset,
  move_input_conditioner_if.master  move_if
);

  localparam int unsigned c_tmax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned c_tw   = (c_tmax < 2) ? 1 : $clog2(c_tmax);
  localparam logic [c_tw-1:0] c_delay_last  = c_tw'(REPEAT_DELAY - 1);
  localparam logic [c_tw-1:0] c_period_last = c_tw'(REPEAT_PERIOD - 1);

  logic [3:0]      raw_n;
  logic [3:0]      held_lvl;
  logic            latched_held;

  move_state_e     state_q, state_d;
  dir_e            dir_q, dir_d;
  logic            rep_q, rep_d;     // current ISSUE is a repeat issue
  logic [c_tw-1:0] timer_q, timer_d;

  assign raw_n = {move_if.move_d, move_if.move_u, move_if.move_l, move_if.move_r};

  for (genvar gi = 0; gi < c_num_buttons; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .VGA_CLK (VGA_CLK),
      .reset   (reset),
      .raw_n_i (raw_n[gi]),
      .level_o (held_lvl[gi])
    );
  end

  // Is the button that started the current sequence still down?
  assign latched_held = held_lvl[dir_q];

  // Move FSM next-state: issue, wait for hold-to-repeat, then demand full release.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rep_d   = rep_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (|held_lvl) begin
          dir_d   = pick_dir(held_lvl);
          rep_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The pending move is never withdrawn; release only changes where we go afterwards.
        if (move_if.move_ready) begin
          timer_d = '0;
          if (!latched_held) begin
            state_d = RELEASE;
          end else if (rep_q) begin
            state_d = REPEAT;
          end else begin
            state_d = DELAY;
          end
        end
      end
      DELAY: begin
        if (!latched_held) begin
          timer_d = '0;
          state_d = RELEASE;
        end else if (timer_q == c_delay_last) begin
          timer_d = '0;
          rep_d   = 1'b1;
          state_d = ISSUE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!latched_held) begin
          timer_d = '0;
          state_d = RELEASE;
        end else if (timer_q == c_period_last) begin
          timer_d = '0;
          rep_d   = 1'b1;
          state_d = ISSUE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELEASE: begin
        // Any button still down, even a different one, blocks new moves.
        timer_d = '0;
        if (held_lvl == 4'b0000) begin
          state_d = IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Move FSM state, latched direction, repeat flag and repeat timer.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_R;
      rep_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rep_q   <= rep_d;
      timer_q <= timer_d;
    end
  end

  assign move_if.move_valid = (state_q == ISSUE);
  assign move_if.move_dir   = dir_q;
  assign move_if.held       = held_lvl;

endmodule
`default_nettype wire

// File: tb/tb_move_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_input_conditioner
// Description : Directed self-checking bench for move_input_conditioner with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
//               Inputs change and outputs are sampled 1 ns after each rising
//               edge; "sample k" is the k-th such point after a stimulus change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_input_conditioner;

  logic VGA_CLK = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  move_input_conditioner_if bus ();

  move_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .move_if (bus)
  );

  always #20 VGA_CLK = ~VGA_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic release_all();
    bus.move_r = 1'b1;
    bus.move_l = 1'b1;
    bus.move_u = 1'b1;
    bus.move_d = 1'b1;
  endtask

  // Release everything and let any pending move drain back to IDLE.
  task automatic settle();
    release_all();
    bus.move_ready = 1'b1;
    repeat (40) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    release_all();
    bus.move_ready = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (bus.move_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.move_valid);
    end
    n_tests++;
    if (bus.move_dir !== 2'd0) begin
      n_fail++; $display("FAIL reset_dir: got %0d expected 0", bus.move_dir);
    end
    n_tests++;
    if (bus.held !== 4'b0000) begin
      n_fail++; $display("FAIL reset_held: got %b expected 0000", bus.held);
    end
    reset = 1'b0;
    tick();
  endtask

  // A 3-cycle press is shorter than the debounce window.
  task automatic test_glitch();
    int held_seen = 0;
    int valid_seen = 0;
    bus.move_ready = 1'b1;
    bus.move_u = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 3) bus.move_u = 1'b1;
      if (bus.held !== 4'b0000) held_seen++;
      if (bus.move_valid !== 1'b0) valid_seen++;
    end
    n_tests++;
    if (held_seen != 0) begin
      n_fail++; $display("FAIL glitch_held: got %0d samples with held set, expected 0", held_seen);
    end
    n_tests++;
    if (valid_seen != 0) begin
      n_fail++; $display("FAIL glitch_valid: got %0d samples with move_valid, expected 0", valid_seen);
    end
  endtask

  // Single press: level accepted at sample 6, one move at sample 7.
  task automatic test_single();
    logic h5, h6;
    int   hs = 0;
    int   dir_bad = 0;
    h5 = 1'bx;
    h6 = 1'bx;
    bus.move_ready = 1'b1;
    bus.move_r = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k == 5) h5 = bus.held[0];
      if (k == 6) h6 = bus.held[0];
      if (k == 10) bus.move_r = 1'b1;
      if (bus.move_valid === 1'b1) begin
        hs++;
        if (bus.move_dir !== 2'd0) dir_bad++;
      end
    end
    n_tests++;
    if (h5 !== 1'b0) begin
      n_fail++; $display("FAIL single_held_early: got %b at sample 5 expected 0", h5);
    end
    n_tests++;
    if (h6 !== 1'b1) begin
      n_fail++; $display("FAIL single_held_on_time: got %b at sample 6 expected 1", h6);
    end
    n_tests++;
    if (hs != 1) begin
      n_fail++; $display("FAIL single_move_count: got %0d moves expected 1", hs);
    end
    n_tests++;
    if (dir_bad != 0) begin
      n_fail++; $display("FAIL single_dir: got %0d moves with dir!=0 expected 0", dir_bad);
    end
    n_tests++;
    if (bus.held !== 4'b0000 || bus.move_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_after_release: got held=%b valid=%b expected 0000/0", bus.held, bus.move_valid);
    end
  endtask

  // Hold down: first move at 7, then 20 idle cycles of delay, then every 8 idle cycles.
  task automatic test_repeat();
    int t [8];
    int exp_t [6];
    int cnt = 0;
    int dir_bad = 0;
    exp_t = '{7, 28, 37, 46, 55, 64};
    for (int i = 0; i < 8; i++) t[i] = -1;
    bus.move_ready = 1'b1;
    bus.move_d = 1'b0;
    for (int k = 1; k <= 85; k++) begin
      tick();
      if (k == 60) bus.move_d = 1'b1;
      if (bus.move_valid === 1'b1) begin
        if (cnt < 8) t[cnt] = k;
        cnt++;
        if (bus.move_dir !== 2'd3) dir_bad++;
      end
    end
    n_tests++;
    if (cnt != 6) begin
      n_fail++; $display("FAIL repeat_count: got %0d moves expected 6", cnt);
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (t[i] != exp_t[i]) begin
        n_fail++; $display("FAIL repeat_time[%0d]: got sample %0d expected %0d", i, t[i], exp_t[i]);
      end
    end
    n_tests++;
    if (dir_bad != 0) begin
      n_fail++; $display("FAIL repeat_dir: got %0d moves with dir!=3 expected 0", dir_bad);
    end
  endtask

  // Left + up together: left wins; up alone stays blocked until fully released.
  task automatic test_simul();
    int hs1 = 0, hs2 = 0, hs3 = 0;
    logic [1:0] d1, d3;
    d1 = 2'bxx;
    d3 = 2'bxx;
    bus.move_ready = 1'b1;
    bus.move_l = 1'b0;
    bus.move_u = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.move_valid === 1'b1) begin hs1++; d1 = bus.move_dir; end
    end
    bus.move_l = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.move_valid === 1'b1) hs2++;
    end
    bus.move_u = 1'b1;
    repeat (15) tick();
    n_tests++;
    if (bus.held !== 4'b0000) begin
      n_fail++; $display("FAIL simul_all_released: got held=%b expected 0000", bus.held);
    end
    bus.move_u = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (bus.move_valid === 1'b1) begin hs3++; d3 = bus.move_dir; end
    end
    n_tests++;
    if (hs1 != 1 || d1 !== 2'd1) begin
      n_fail++; $display("FAIL simul_first: got %0d moves dir=%0d expected 1 move dir=1", hs1, d1);
    end
    n_tests++;
    if (hs2 != 0) begin
      n_fail++; $display("FAIL simul_blocked: got %0d moves while up still held expected 0", hs2);
    end
    n_tests++;
    if (hs3 != 1 || d3 !== 2'd2) begin
      n_fail++; $display("FAIL simul_repress: got %0d moves dir=%0d expected 1 move dir=2", hs3, d3);
    end
    settle();
  endtask

  // Back-pressure: move held stable for 15 cycles, accepted once when ready rises.
  task automatic test_backpressure();
    int n = 0;
    int bad = 0;
    int hs = 0;
    bus.move_ready = 1'b0;
    bus.move_r = 1'b0;
    while (bus.move_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (bus.move_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_wait_valid: got timeout after %0d cycles expected move_valid", n);
    end
    for (int i = 0; i < 15; i++) begin
      if (i > 0) tick();
      if (bus.move_valid !== 1'b1 || bus.move_dir !== 2'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
    end
    bus.move_ready = 1'b1;
    if (bus.move_valid === 1'b1) hs++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.move_valid === 1'b1) hs++;
    end
    n_tests++;
    if (hs != 1) begin
      n_fail++; $display("FAIL bp_accept_once: got %0d accepted moves expected 1", hs);
    end
    settle();
  endtask

  // Reset while a move is pending, button still down: fresh debounce before next move.
  task automatic test_reset_mid();
    int n = 0;
    int first = -1;
    bus.move_ready = 1'b0;
    bus.move_r = 1'b0;
    while (bus.move_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (bus.move_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_wait_valid: got timeout after %0d cycles expected move_valid", n);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (bus.move_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", bus.move_valid);
    end
    n_tests++;
    if (bus.held !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_held: got %b expected 0000", bus.held);
    end
    reset = 1'b0;
    bus.move_ready = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.move_valid === 1'b1 && first < 0) first = k;
    end
    n_tests++;
    if (first != 7) begin
      n_fail++; $display("FAIL rst_mid_redebounce: got first move at sample %0d expected 7", first);
    end
    settle();
  endtask

  initial begin
    reset = 1'b1;
    bus.move_ready = 1'b0;
    release_all();
    test_reset();
    test_glitch();
    test_single();
    test_repeat();
    test_simul();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/move_input_conditioner.md
MOVE_INPUT_CONDITIONER -- requirements
Module: move_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable synchronized samples (10 ms at 25 MHz) before a button level is accepted.
REQ-002 Parameter REPEAT_DELAY, default 12500000, cycles a button is held after its first move before auto-repeat starts (0.5 s).
REQ-003 Parameter REPEAT_PERIOD, default 5000000, cycles between auto-repeat moves (0.2 s).
REQ-004 VGA_CLK  input  1  clock, 25 MHz pixel clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 move_r, move_l, move_u, move_d  input  1 each  raw active-low push buttons; asynchronous to VGA_CLK.
REQ-007 move_ready  input  1  consumer accepts the current move when high.
REQ-008 move_valid  output  1  move command pending.
REQ-009 move_dir  output  2  direction: 0=right, 1=left, 2=up, 3=down.
REQ-010 held  output  4  debounced pressed levels, active-high, bit order {d,u,l,r}.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer, inverted to active-high, before debouncing.
REQ-012 A debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any sample equal to the current level SHALL clear that channel's counter.
REQ-013 FSM states: IDLE, ISSUE, DELAY, REPEAT, RELEASE.
REQ-014 IDLE: on any held bit set, latch direction by priority r > l > u > d, go to ISSUE.
REQ-015 ISSUE: move_valid=1 with the latched move_dir; both SHALL hold stable until move_valid && move_ready; on that handshake cycle go to DELAY (first issue) or REPEAT (repeat issue), timer cleared.
REQ-016 Exactly one move SHALL be accepted per handshake; move_valid SHALL deassert the cycle after acceptance.
REQ-017 DELAY: timer counts up; when timer reaches REPEAT_DELAY-1 with the latched button still held, go to ISSUE as a repeat issue.
REQ-018 REPEAT: timer counts up; when timer reaches REPEAT_PERIOD-1 with the latched button still held, go to ISSUE as a repeat issue.
REQ-019 In DELAY or REPEAT, release of the latched button SHALL go to RELEASE immediately, timer cleared.
REQ-020 RELEASE: wait until held==0, then IDLE; no move is issued while any button remains held, including a newly pressed different button.
REQ-021 Button release while in ISSUE SHALL NOT withdraw the pending move; after acceptance, go to RELEASE instead of DELAY/REPEAT.
REQ-022 Simultaneous first presses SHALL resolve by REQ-014 priority; the others are ignored until full release.
REQ-023 Timer width SHALL be $clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD; no wrap-around SHALL occur (timer saturates to 0 on state exit).
REQ-024 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) per channel.

Reset
REQ-025 On reset: synchronizer flops, debounced levels, and counters = 0; FSM = IDLE; move_valid=0, move_dir=0, held=0.
REQ-026 Reset asserted mid-ISSUE SHALL drop move_valid on the next edge without a handshake; a button still pressed after reset SHALL be re-debounced before any move.

Structure
REQ-027 Direction encodings (DIR_R, DIR_L, DIR_U, DIR_D) and FSM state enum SHALL live in shared package frogger_pkg, also used by the frog-position logic.
REQ-028 One sub-module debounce_channel (synchronizer + counter + level) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-029 move_u pulled low for 3 cycles then high -> held stays 0, no move_valid.
REQ-030 move_r held low 10 cycles, move_ready=1 -> held[0]=1 at cycle 2+4, one move_valid pulse with move_dir=0, then RELEASE after button up, no second move.
REQ-031 move_d held low 60 cycles, move_ready=1 -> first move, then repeats 20 cycles after the first and every 8 cycles thereafter, all move_dir=3.
REQ-032 move_l and move_u pressed same cycle -> single move_dir=1; after releasing move_l only, no move issued until move_u also released and re-pressed.
REQ-033 move_r pressed, move_ready=0 for 15 cycles then 1 -> move_valid high and move_dir=0 stable all 15 cycles, accepted once on cycle move_ready rises.
REQ-034 reset pulsed while move_valid=1 -> move_valid=0 next cycle, held=0; held button issues a fresh move only after re-debounce.
